bus_rr_arbiter: RTL and testbench
=================================

// Module: bus_rr_arbiter
// PURPOSE
//  Round-robin controller for the shared packet bus between drvrs terminal FIFOs.
//  Each FIFO flags pending data (pndng) and presents its head packet (D_pop).
//  The arbiter grants one source at a time, pops its head packet, decodes the
//  destination ID, and pushes the packet into the destination FIFO(s).
//  It sits between the per-terminal FIFOs and the bus_if seen by driver/monitor.
// PARAMETERS
//  drvrs     4      number of terminals on the bus (2..16)
//  pckg_sz   16     packet width in bits; [pckg_sz-1 -: 8] = dest ID, rest = payload (>=9)
//  broadcast 8'hFF  dest ID that delivers to every terminal except the source
// PORTS
//  clk      in   1              bus clock, rising edge
//  reset    in   1              async, active-low; 0 = reset
//  pndng    in   drvrs          FIFO i holds at least one packet; D_pop[i] valid while high
//  D_pop    in   drvrs*pckg_sz  head packet of FIFO i at bits [i*pckg_sz +: pckg_sz]
//  pop      out  drvrs          one-cycle pulse: FIFO i dequeues its head
//  push     out  drvrs          one-cycle pulse: FIFO i enqueues its D_push lane
//  D_push   out  drvrs*pckg_sz  packet to deliver, same value replicated on every lane
//  grant    out  drvrs          one-hot current owner; 0 when the bus is idle
//  busy     out  1              high in the POP and PUSH states
//  drop_err out  1              one-cycle pulse: packet discarded because dest was invalid
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; pop, push, grant, D_push, busy, drop_err = 0.
//   The RR pointer resets to drvrs-1, so driver 0 has the highest priority first.
//   All outputs are registered.
//  FSM states: IDLE -> POP -> PUSH -> IDLE. One packet takes 3 cycles.
//  IDLE
//   - If pndng == 0, stay in IDLE.
//   - Otherwise pick the first i with pndng[i]=1, scanning ptr+1, ptr+2, ... (mod drvrs).
//   - Register grant = onehot(i) and go to POP.
//  POP
//   - If pndng[g] = 1: pulse pop[g] for one cycle, latch pkt = D_pop[g], set ptr = g,
//     and go to PUSH.
//   - If pndng[g] = 0 (source went empty): no pop; clear grant; return to IDLE.
//     The pointer does not change.
//  PUSH
//   - Decode dest = pkt[pckg_sz-1 -: 8]. Drive D_push = pkt on all lanes.
//   - dest < drvrs and dest != g: push = onehot(dest).
//   - dest == broadcast: push = all ones with bit g cleared.
//   - dest == g (self-send): treated as a normal unicast; push = onehot(g).
//   - dest >= drvrs and dest != broadcast: push = 0 and drop_err pulses.
//   - Then clear grant and return to IDLE.
//  Latency: pndng[i] rises at edge t -> pop[i] is high in cycle t+1 -> push is high
//   in cycle t+2. The next grant is decided in IDLE at t+3, so maximum throughput is
//   1 packet per 3 cycles.
//  Fairness: once served, a driver has the lowest priority. With all requesters
//   active, the grant order is 0,1,..,drvrs-1,0,... and no requester waits more
//   than drvrs grants.
//  Payload bits pass through unchanged; the dest ID byte is not stripped.
//  The full flag of the destination FIFO is not checked. Overflow is the FIFO's
//   responsibility.
//  pop and push are never both high for the same index in the same cycle.
//  At most one pop bit is high in any cycle.
//  Reset mid-operation: a packet that was popped but not yet pushed is lost.
//   This is accepted behaviour; the scoreboard must flush expectations on reset.
// TESTING
//  1. Single unicast, drvrs=4, pckg_sz=16
//     - Stimulus: pndng=0001, D_pop[0]=16'h02AB.
//     - Response: pop=0001 at t+1; push=0100 with D_push=16'h02AB at t+2; busy high
//       for 2 cycles.
//  2. All four drivers pending continuously
//     - Response: grant order 0,1,2,3,0; one pop every 3 cycles; no requester skipped.
//  3. Broadcast
//     - Stimulus: driver 2 sends 16'hFF55.
//     - Response: push=1011; every lane D_push=16'hFF55; drop_err stays 0.
//  4. Invalid destination
//     - Stimulus: driver 1 sends 16'h0733.
//     - Response: pop[1] pulses; push stays 0; drop_err pulses once at t+2.
//  5. Source goes empty
//     - Stimulus: pndng[3] drops during the POP cycle.
//     - Response: no pop and no push; FSM returns to IDLE; next grant still starts
//       from the old pointer.
//  6. Reset mid-operation
//     - Stimulus: assert reset=0 during PUSH.
//     - Response: all outputs are 0 immediately (async). After release, the first
//       grant goes to driver 0.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for the shared packet bus: grants one terminal FIFO at a time,
// pops its head packet and pushes it into the destination FIFO(s), one packet per 3 cycles.
module bus_rr_arbiter #(
  parameter int          drvrs     = 4,
  parameter int          pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  output logic [drvrs-1:0]           push,
  output logic [drvrs*pckg_sz-1:0]   D_push,
  output logic [drvrs-1:0]           grant,
  output logic                       busy,
  output logic                       drop_err
);

  localparam int PW = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  state_t              state;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       gidx;
  logic [PW-1:0]       next_idx;
  logic [pckg_sz-1:0]  pkt;
  logic [7:0]          dest;

  function automatic logic [drvrs-1:0] onehot(input int idx);
    return drvrs'(1) << idx;
  endfunction

  // First requester after p (mod drvrs); descending scan lets the nearest one win.
  function automatic logic [PW-1:0] rr_pick(input logic [drvrs-1:0] req,
                                            input logic [PW-1:0]    p);
    logic [PW-1:0]    sel;
    logic [drvrs-1:0] sh;
    int               idx;
    sel = p;
    for (int k = drvrs; k >= 1; k--) begin
      idx = (int'(p) + k) % drvrs;
      sh  = req >> idx;
      if (sh[0]) sel = PW'(idx);
    end
    return sel;
  endfunction

  assign next_idx = rr_pick(pndng, ptr);
  assign dest     = pkt[pckg_sz-1 -: 8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= PW'(drvrs - 1);
      gidx     <= '0;
      grant    <= '0;
      pop      <= '0;
      push     <= '0;
      busy     <= 1'b0;
      drop_err <= 1'b0;
      D_push   <= '0;
    end else begin
      pop      <= '0;
      push     <= '0;
      drop_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|pndng) begin
            gidx  <= next_idx;
            grant <= onehot(int'(next_idx));
            busy  <= 1'b1;
            state <= POP;
          end
        end
        POP: begin
          // A source that emptied before its pop forfeits the grant; ptr is untouched.
          if (pndng[gidx]) begin
            pop   <= grant;
            ptr   <= gidx;
            state <= PUSH;
          end else begin
            grant <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        PUSH: begin
          D_push <= {drvrs{pkt}};
          if (dest == broadcast)
            push <= ~grant;
          else if (int'(dest) < drvrs)
            push <= onehot(int'(dest));
          else
            drop_err <= 1'b1;
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Packet holding register: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (state == POP)
      pkt <= D_pop[gidx*pckg_sz +: pckg_sz];
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: directed packets through small FIFO models,
// expected pops/pushes queued by the stimulus and checked by a separate monitor.
module tb_bus_rr_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   pndng = '0;
  logic [N*W-1:0] D_pop = '0;
  logic [N-1:0]   pop, push, grant;
  logic [N*W-1:0] D_push;
  logic           busy, drop_err;

  always #5 clk = ~clk;

  bus_rr_arbiter #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push), .grant(grant),
    .busy(busy), .drop_err(drop_err)
  );

  typedef struct {
    logic [N-1:0] m;
    logic [W-1:0] d;
    logic         drop;
  } push_t;

  logic [N-1:0] pop_q[$];
  push_t        psh_q[$];

  int  tests = 0;
  int  fails = 0;
  int  timeouts = 0;
  bit  done = 1'b0;

  logic [W-1:0] fifo_mem [N][8];
  int           wr [N] = '{default: 0};
  int           rd [N] = '{default: 0};
  logic [N-1:0] mask = '0;

  // ---------------- FIFO environment and stimulus helpers ----------------
  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      pndng[i]       = (rd[i] < wr[i]) && !mask[i];
      D_pop[i*W +: W] = (rd[i] < wr[i]) ? fifo_mem[i][rd[i]] : '0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (pop[i] && rd[i] < wr[i]) rd[i]++;
    refresh();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(input int d, input logic [W-1:0] p);
    fifo_mem[d][wr[d]] = p;
    wr[d]++;
  endtask

  task automatic xpop(input logic [N-1:0] m);
    pop_q.push_back(m);
  endtask

  task automatic xpush(input logic [N-1:0] m, input logic [W-1:0] d, input logic drop);
    push_t e;
    e.m = m; e.d = d; e.drop = drop;
    psh_q.push_back(e);
  endtask

  task automatic wait_grant();
    for (int k = 0; k < 20 && grant == '0; k++) tick();
    if (grant == '0) begin
      timeouts++;
      $display("FAIL wait_grant: grant=%b, required nonzero within 20 cycles", grant);
    end
  endtask

  // ---------------- Monitor / scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  initial begin : monitor
    int    cyc;
    int    last_pop;
    int    pi;
    int    qi;
    push_t e;
    cyc = 0; last_pop = -10; pi = 0; qi = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        check("reset_ctrl", 64'({pop, push, grant, busy, drop_err}), 64'd0);
        check("reset_dpush", 64'(D_push), 64'd0);
      end else begin
        check("busy_vs_grant", 64'(busy), 64'(grant != '0));
        if (pop != '0) begin
          if (pi < pop_q.size()) begin
            check("pop_mask", 64'(pop), 64'(pop_q[pi]));
            pi++;
          end else
            check("unexpected_pop", 64'(pop), 64'd0);
          check("grant_at_pop", 64'(grant), 64'(pop));
          check("busy_at_pop", 64'(busy), 64'd1);
          last_pop = cyc;
        end
        if (push != '0 || drop_err) begin
          if (qi < psh_q.size()) begin
            e = psh_q[qi];
            qi++;
            check("push_mask", 64'(push), 64'(e.m));
            check("push_data", 64'(D_push), 64'({N{e.d}}));
            check("drop_err", 64'(drop_err), 64'(e.drop));
          end else
            check("unexpected_push", 64'({push, drop_err}), 64'd0);
          check("push_latency", 64'(cyc), 64'(last_pop + 1));
          check("pop_push_overlap", 64'(pop & push), 64'd0);
        end
      end
      if (done) begin
        check("all_pops_seen", 64'(pi), 64'(pop_q.size()));
        check("all_pushes_seen", 64'(qi), 64'(psh_q.size()));
        check("no_timeouts", 64'(timeouts), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation still running at 100000 ns, required to finish");
    $fatal(1);
  end

  // ---------------- Directed stimulus ----------------
  initial begin : stimulus
    ticks(3);
    reset = 1'b1;
    ticks(2);

    // All four pending continuously: order 0,1,2,3,0,1,2,3
    load(0, 16'h0100); load(0, 16'h0210);
    load(1, 16'h0201); load(1, 16'h0311);
    load(2, 16'h0302); load(2, 16'h0012);
    load(3, 16'h0003); load(3, 16'h0113);
    refresh();
    xpop(4'b0001); xpush(4'b0010, 16'h0100, 1'b0);
    xpop(4'b0010); xpush(4'b0100, 16'h0201, 1'b0);
    xpop(4'b0100); xpush(4'b1000, 16'h0302, 1'b0);
    xpop(4'b1000); xpush(4'b0001, 16'h0003, 1'b0);
    xpop(4'b0001); xpush(4'b0100, 16'h0210, 1'b0);
    xpop(4'b0010); xpush(4'b1000, 16'h0311, 1'b0);
    xpop(4'b0100); xpush(4'b0001, 16'h0012, 1'b0);
    xpop(4'b1000); xpush(4'b0010, 16'h0113, 1'b0);
    ticks(30);

    // Single unicast 0 -> 2
    load(0, 16'h02AB); refresh();
    xpop(4'b0001); xpush(4'b0100, 16'h02AB, 1'b0);
    ticks(8);

    // Broadcast from driver 2
    load(2, 16'hFF55); refresh();
    xpop(4'b0100); xpush(4'b1011, 16'hFF55, 1'b0);
    ticks(8);

    // Invalid destination from driver 1, then self-send
    load(1, 16'h0733); refresh();
    xpop(4'b0010); xpush(4'b0000, 16'h0733, 1'b1);
    ticks(8);
    load(1, 16'h0144); refresh();
    xpop(4'b0010); xpush(4'b0010, 16'h0144, 1'b0);
    ticks(8);

    // Driver 3 empties during POP; pointer stays at 1 so order is 2,3,0
    load(3, 16'h0205); refresh();
    wait_grant();
    mask[3] = 1'b1; refresh();
    ticks(6);
    mask[3] = 1'b0;
    load(0, 16'h0306); load(2, 16'h0107); refresh();
    xpop(4'b0100); xpush(4'b0010, 16'h0107, 1'b0);
    xpop(4'b1000); xpush(4'b0100, 16'h0205, 1'b0);
    xpop(4'b0001); xpush(4'b1000, 16'h0306, 1'b0);
    ticks(14);

    load(3, 16'h0008); refresh();
    xpop(4'b1000); xpush(4'b0001, 16'h0008, 1'b0);
    ticks(8);

    // Reset while driver 0 is being served; afterwards driver 0 goes first again
    load(0, 16'h0209); load(1, 16'h030A); refresh();
    wait_grant();
    @(posedge clk);
    #1 reset = 1'b0;
    xpop(4'b0001); xpush(4'b0100, 16'h0209, 1'b0);
    xpop(4'b0010); xpush(4'b1000, 16'h030A, 1'b0);
    ticks(2);
    reset = 1'b1;
    ticks(12);

    done = 1'b1;
  end

endmodule
